// File: rtl/imem_loader_if.sv
// Byte-stream intake and instruction-memory write bus
// shared by the boot loader and its surroundings.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed, XOR-checked image
// into instruction memory and holds the core in reset until verified.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  imem_loader_if.slave    bus,
  output logic            core_rst,
  output logic            load_done,
  output logic            err,
  output logic [ADDR_W:0] words_loaded
);

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CHK    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        csum_q, csum_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              crst_q, crst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   words_q, words_d;

  logic            ready;
  logic            acc;
  logic [16:0]     n_full;
  logic [ADDR_W:0] words_inc;

  assign ready = rst && (state_q == S_LEN_LO ||
                         state_q == S_LEN_HI ||
                         state_q == S_DATA   ||
                         state_q == S_CHK);
  assign acc       = bus.byte_valid && ready;
  assign n_full    = {1'b0, bus.byte_data, len_lo_q};
  assign words_inc = words_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    csum_d   = csum_q;
    bcnt_d   = bcnt_q;
    wptr_d   = wptr_q;
    asm_d    = asm_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    crst_d   = crst_q;
    done_d   = done_q;
    err_d    = err_q;
    words_d  = words_q;
    if (acc) begin
      unique case (1'b1)
        (state_q == S_LEN_LO): begin
          len_lo_d = bus.byte_data;
          csum_d   = 8'h00;
          state_d  = S_LEN_HI;
        end
        (state_q == S_LEN_HI): begin
          len_d = n_full[ADDR_W:0];
          if (n_full == 17'd0 || n_full > CAP) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
        (state_q == S_DATA): begin
          csum_d = csum_q ^ bus.byte_data;
          bcnt_d = bcnt_q + 2'd1;
          asm_d  = {bus.byte_data, asm_q[23:8]};
          // 4th byte completes the word; byte 0 sits at [7:0]
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = wptr_q;
            wdata_d = {bus.byte_data, asm_q};
            wptr_d  = wptr_q + 1'b1;
            words_d = words_inc;
            if (words_inc == len_q) begin
              state_d = S_CHK;
            end
          end
        end
        (state_q == S_CHK): begin
          if (bus.byte_data == csum_q) begin
            done_d  = 1'b1;
            crst_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_LEN_LO;
      len_lo_q <= '0;
      len_q    <= '0;
      csum_q   <= '0;
      bcnt_q   <= '0;
      wptr_q   <= '0;
      asm_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      crst_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      csum_q   <= csum_d;
      bcnt_q   <= bcnt_d;
      wptr_q   <= wptr_d;
      asm_q    <= asm_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      crst_q   <= crst_d;
      done_q   <= done_d;
      err_q    <= err_d;
      words_q  <= words_d;
    end
  end

  assign bus.byte_ready = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_rst       = crst_q;
  assign load_done      = done_q;
  assign err            = err_q;
  assign words_loaded   = words_q;

endmodule
